// File: rtl/systolic_tile_engine.sv
// Output-stationary ROWS x COLS signed MAC grid with skewed operand feeds and row-by-row drain.
// Build option PE_SAT_EN: saturating accumulation plus a sticky sat_flag output.
module systolic_tile_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_MAX  = 256,
    localparam int KW    = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    acc_keep,
    input  logic [KW-1:0]           k_len,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DATA_W-1:0]  a_data,
    input  logic [COLS*DATA_W-1:0]  b_data,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [COLS*ACC_W-1:0]   c_data,
    output logic                    c_last
`ifdef PE_SAT_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int FW = $clog2(ROWS + COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t state, state_next;

    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_idx;
    logic          in_fire;
    logic          beat_last;
    logic          row_last;
    logic          acc_clear;

    logic [DATA_W-1:0]       a_edge [ROWS];
    logic [ROWS-1:0]         v_edge;
    logic [DATA_W-1:0]       b_edge [COLS];
    logic [DATA_W-1:0]       a_fwd  [ROWS][COLS-1];
    logic                    v_fwd  [ROWS][COLS-1];
    logic [DATA_W-1:0]       b_fwd  [ROWS-1][COLS];
    logic signed [ACC_W-1:0] acc    [ROWS][COLS];
`ifdef PE_SAT_EN
    logic [ROWS*COLS-1:0]    sat_hit;
`endif

    assign in_fire   = in_valid && in_ready;
    assign beat_last = in_fire && (k_cnt == k_len_q - KW'(1));
    assign row_last  = (row_idx == RW'(ROWS - 1));
    assign acc_clear = (state == IDLE) && start && !acc_keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (k_len == '0) ? DRAIN : STREAM;
            STREAM:  if (beat_last) state_next = FLUSH;
            FLUSH:   if (flush_cnt == FW'(ROWS + COLS - 2)) state_next = DRAIN;
            DRAIN:   if (c_ready && row_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == STREAM);
        c_valid  = (state == DRAIN);
        c_last   = (state == DRAIN) && row_last;
    end

    // Flush length is fixed so the last token has cleared the far corner PE before draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_q   <= '0;
            k_cnt     <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && c_ready && row_last;
            if ((state == IDLE) && start) begin
                k_len_q   <= k_len;
                k_cnt     <= '0;
                flush_cnt <= '0;
                row_idx   <= '0;
            end
            if (in_fire)
                k_cnt <= k_cnt + KW'(1);
            if (state == FLUSH)
                flush_cnt <= flush_cnt + FW'(1);
            if ((state == DRAIN) && c_ready)
                row_idx <= row_last ? '0 : row_idx + RW'(1);
        end
    end

    always_comb begin
        c_data = '0;
        for (int j = 0; j < COLS; j++)
            c_data[j*ACC_W +: ACC_W] = c_valid ? acc[row_idx][j] : '0;
    end

`ifdef PE_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        sat_flag <= 1'b0;
        else if ((state == IDLE) && start) sat_flag <= 1'b0;
        else if (|sat_hit)              sat_flag <= 1'b1;
    end
`endif

    genvar gi, gj;

    // Row i of A (with its valid token) and column j of B enter the grid i / j cycles late.
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_data[gi*DATA_W +: DATA_W];
            assign v_edge[gi] = in_fire;
        end else begin : g_delay
            logic [DATA_W-1:0] a_dly [gi];
            logic [gi-1:0]     v_dly;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < gi; d++) a_dly[d] <= '0;
                    v_dly <= '0;
                end else begin
                    a_dly[0] <= a_data[gi*DATA_W +: DATA_W];
                    v_dly[0] <= in_fire;
                    for (int d = 1; d < gi; d++) begin
                        a_dly[d] <= a_dly[d-1];
                        v_dly[d] <= v_dly[d-1];
                    end
                end
            end
            assign a_edge[gi] = a_dly[gi-1];
            assign v_edge[gi] = v_dly[gi-1];
        end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_b_skew
        if (gj == 0) begin : g_direct
            assign b_edge[gj] = b_data[gj*DATA_W +: DATA_W];
        end else begin : g_delay
            logic [DATA_W-1:0] b_dly [gj];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < gj; d++) b_dly[d] <= '0;
                end else begin
                    b_dly[0] <= b_data[gj*DATA_W +: DATA_W];
                    for (int d = 1; d < gj; d++) b_dly[d] <= b_dly[d-1];
                end
            end
            assign b_edge[gj] = b_dly[gj-1];
        end
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_pe
            logic [DATA_W-1:0]         a_in, b_in;
            logic                      v_in;
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0]   prod_ext, acc_r, acc_next;

            if (gj == 0) begin : g_left
                assign a_in = a_edge[gi];
                assign v_in = v_edge[gi];
            end else begin : g_from_left
                assign a_in = a_fwd[gi][gj-1];
                assign v_in = v_fwd[gi][gj-1];
            end

            if (gi == 0) begin : g_top
                assign b_in = b_edge[gj];
            end else begin : g_from_top
                assign b_in = b_fwd[gi-1][gj];
            end

            if (gj < COLS - 1) begin : g_fwd_right
                logic [DATA_W-1:0] a_r;
                logic              v_r;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_r <= '0;
                        v_r <= 1'b0;
                    end else begin
                        a_r <= a_in;
                        v_r <= v_in;
                    end
                end
                assign a_fwd[gi][gj] = a_r;
                assign v_fwd[gi][gj] = v_r;
            end

            if (gi < ROWS - 1) begin : g_fwd_down
                logic [DATA_W-1:0] b_r;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) b_r <= '0;
                    else     b_r <= b_in;
                end
                assign b_fwd[gi][gj] = b_r;
            end

            assign prod     = (2*DATA_W)'($signed(a_in)) * (2*DATA_W)'($signed(b_in));
            assign prod_ext = ACC_W'(prod);

`ifdef PE_SAT_EN
            localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
            logic signed [ACC_W:0] sum_w;
            logic                  ovf;
            assign sum_w    = (ACC_W+1)'(acc_r) + (ACC_W+1)'(prod_ext);
            assign ovf      = (sum_w[ACC_W] != sum_w[ACC_W-1]);
            assign acc_next = ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
            assign sat_hit[gi*COLS+gj] = v_in && ovf;
`else
            assign acc_next = acc_r + prod_ext;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst)            acc_r <= '0;
                else if (acc_clear) acc_r <= '0;
                else if (v_in)      acc_r <= acc_next;
            end
            assign acc[gi][gj] = acc_r;
        end
    end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Self-checking bench for systolic_tile_engine: directed GEMM tiles plus random tiles against a matrix model.
module tb_systolic_tile_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int K_MAX  = 256;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int CW     = COLS * ACC_W;
    localparam int TK     = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   acc_keep;
    logic [KW-1:0]          k_len;
    logic                   busy;
    logic                   done;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] a_data;
    logic [COLS*DATA_W-1:0] b_data;
    logic                   c_valid;
    logic                   c_ready;
    logic [CW-1:0]          c_data;
    logic                   c_last;
`ifdef PE_SAT_EN
    logic                   sat_flag;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int a_mat   [ROWS][TK];
    int b_mat   [TK][COLS];
    int model_c [ROWS][COLS];

    systolic_tile_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .acc_keep(acc_keep), .k_len(k_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .b_data(b_data), .c_valid(c_valid), .c_ready(c_ready),
        .c_data(c_data), .c_last(c_last)
`ifdef PE_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [CW-1:0] exp_row(input int r);
        logic [CW-1:0] v;
        v = '0;
        for (int j = 0; j < COLS; j++) v[j*ACC_W +: ACC_W] = model_c[r][j];
        return v;
    endfunction

    // Reference: C += A[:,k] * B[k,:] for every accepted beat, 32-bit wrap (or clamp when saturating).
    task automatic model_beat(input int k);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
`ifdef PE_SAT_EN
                longint s;
                s = longint'(model_c[i][j]) + longint'(a_mat[i][k] * b_mat[k][j]);
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
                model_c[i][j] = int'(s);
`else
                model_c[i][j] = model_c[i][j] + a_mat[i][k] * b_mat[k][j];
`endif
            end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) model_c[i][j] = 0;
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < ROWS; i++) a_data[i*DATA_W +: DATA_W] = a_mat[i][k][DATA_W-1:0];
        for (int j = 0; j < COLS; j++) b_data[j*DATA_W +: DATA_W] = b_mat[k][j][DATA_W-1:0];
    endtask

    // Runs one full tile; bubbles toggles in_valid 1,0,1,0 and holds a stray start high during streaming.
    task automatic apply_stimulus(input string name, input int k, input bit keep, input bit bubbles,
                                  input int stall, input bit check_latency);
        int beat, guard, first_acc;
        @(negedge clk);
        check_output({name, "_idle_before"}, CW'(busy), CW'(0));
        check_output({name, "_no_done_before"}, CW'(done), CW'(0));
        start = 1'b1; k_len = KW'(k); acc_keep = keep;
        if (!keep) model_clear();
        @(negedge clk);
        start = 1'b0;
        check_output({name, "_busy"}, CW'(busy), CW'(1));
        beat = 0; guard = 0; first_acc = -1;
        while (beat < k && guard < 4 * k + 20) begin
            if (bubbles) begin
                start = 1'b1; k_len = '0; acc_keep = 1'b0;
            end
            if (bubbles && (guard % 2 == 1)) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                drive_beat(beat);
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                model_beat(beat);
                beat++;
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0;
        if (beat < k) check_output({name, "_beats_accepted"}, CW'(beat), CW'(k));
        check_output({name, "_in_ready_drop"}, CW'(in_ready), CW'(0));
        guard = 0;
        while (!c_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output({name, "_c_valid_seen"}, CW'(c_valid), CW'(1));
        if (check_latency)
            check_output({name, "_latency"}, CW'(cyc - first_acc), CW'(k + ROWS + COLS - 1));
        for (int r = 0; r < ROWS; r++) begin
            c_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                check_output($sformatf("%s_stall_row%0d", name, r), c_data, exp_row(r));
                @(negedge clk);
            end
            c_ready = 1'b1;
            check_output($sformatf("%s_valid_row%0d", name, r), CW'(c_valid), CW'(1));
            check_output($sformatf("%s_row%0d", name, r), c_data, exp_row(r));
            check_output($sformatf("%s_last_row%0d", name, r), CW'(c_last), CW'(r == ROWS - 1));
            @(negedge clk);
        end
        c_ready = 1'b0;
        check_output({name, "_done"}, CW'(done), CW'(1));
        check_output({name, "_c_valid_after"}, CW'(c_valid), CW'(0));
        check_output({name, "_busy_after"}, CW'(busy), CW'(0));
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < ROWS; i++) a_mat[i][kk] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < COLS; j++) b_mat[kk][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic fill_const(input int k, input int av, input int bv);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < ROWS; i++) a_mat[i][kk] = av;
            for (int j = 0; j < COLS; j++) b_mat[kk][j] = bv;
        end
    endtask

    task automatic fill_identity();
        for (int kk = 0; kk < 4; kk++) begin
            for (int i = 0; i < ROWS; i++) a_mat[i][kk] = (i == kk) ? 1 : 0;
            for (int j = 0; j < COLS; j++) b_mat[kk][j] = 4 * kk + j + 1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; acc_keep = 1'b0; k_len = '0;
        in_valid = 1'b0; c_ready = 1'b0; a_data = '0; b_data = '0;
        model_clear();
        $display("[TB] reset checks");
        @(negedge clk);
        check_output("rst_busy", CW'(busy), CW'(0));
        check_output("rst_in_ready", CW'(in_ready), CW'(0));
        check_output("rst_c_valid", CW'(c_valid), CW'(0));
        check_output("rst_c_data", c_data, '0);
        check_output("rst_done", CW'(done), CW'(0));
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] T1 single beat, b = 1..4");
        for (int i = 0; i < ROWS; i++) a_mat[i][0] = 1;
        for (int j = 0; j < COLS; j++) b_mat[0][j] = j + 1;
        apply_stimulus("t1", 1, 1'b0, 1'b0, 0, 1'b1);
        check_output("t1_const_row", exp_row(2), {32'd4, 32'd3, 32'd2, 32'd1});

        $display("[TB] T2 identity A");
        fill_identity();
        apply_stimulus("t2", 4, 1'b0, 1'b0, 0, 1'b1);
        check_output("t2_const_row3", exp_row(3), {32'd16, 32'd15, 32'd14, 32'd13});

        $display("[TB] T3 extreme operands");
        fill_const(3, -128, -128);
        apply_stimulus("t3a", 3, 1'b0, 1'b0, 0, 1'b1);
        check_output("t3a_const", CW'(model_c[1][2]), CW'(49152));
        fill_const(3, -128, 127);
        apply_stimulus("t3b", 3, 1'b0, 1'b0, 1, 1'b1);
        check_output("t3b_const", CW'(model_c[3][0]), CW'(32'(-48768)));

        $display("[TB] T4 bubbles and drain stalls");
        fill_identity();
        apply_stimulus("t4", 4, 1'b0, 1'b1, 5, 1'b0);

        $display("[TB] T5 K-split accumulation");
        fill_random(2);
        apply_stimulus("t5a", 2, 1'b0, 1'b0, 0, 1'b1);
        fill_random(2);
        apply_stimulus("t5b", 2, 1'b1, 1'b0, 0, 1'b1);
        fill_random(2);
        apply_stimulus("t5c", 2, 1'b0, 1'b0, 0, 1'b1);

        $display("[TB] T6 reset mid-stream");
        fill_random(5);
        @(negedge clk);
        start = 1'b1; k_len = KW'(5); acc_keep = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; drive_beat(0);
        @(negedge clk);
        drive_beat(1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_output("t6_rst_busy", CW'(busy), CW'(0));
        check_output("t6_rst_in_ready", CW'(in_ready), CW'(0));
        check_output("t6_rst_c_valid", CW'(c_valid), CW'(0));
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_output("t6_no_done", CW'(done), CW'(0));
        apply_stimulus("t6_k0", 0, 1'b1, 1'b0, 0, 1'b0);

        $display("[TB] random tiles");
        for (int t = 0; t < 6; t++) begin
            int k;
            k = int'($urandom_range(1, 12));
            fill_random(k);
            apply_stimulus($sformatf("rnd%0d", t), k, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
